// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, byte and state types, byte
// access helpers (FIPS-197 order, byte 0 in the most significant position)
// and the FSM encoding of the iterative InvSubBytes engine.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef logic [7:0]             aes_byte_t;
    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } isb_state_e;

    // Byte i of a state occupies bits [127-8i -: 8].
    function automatic aes_byte_t get_byte(input aes_state_t s, input int unsigned i);
        return s[AES_STATE_W-1-8*i -: 8];
    endfunction

    function automatic aes_state_t set_byte(input aes_state_t s, input int unsigned i,
                                            input aes_byte_t b);
        aes_state_t r;
        r = s;
        r[AES_STATE_W-1-8*i -: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready bus of the InvSubBytes engine: input state handshake plus
// the result handshake toward AddRoundKey.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic       valid_in;
    aes_state_t data_in;
    logic       ready_out;
    logic       valid_out;
    aes_state_t data_out;
    logic       ready_in;

    // Upstream/downstream side (drives the state, consumes the result).
    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out
    );

    // Engine side.
    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out
    );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box. Output forced to zero when not enabled
// so idle lookups do not toggle downstream merge logic.
module inv_sbox
    import aes_pkg::*;
(
    input  logic      valid_in,
    input  aes_byte_t addr,
    output aes_byte_t dout
);

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout = valid_in ? INV_SBOX[addr] : 8'h00;

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: captures one state, substitutes
// BYTES_PER_CYCLE bytes per clock in place, then presents the result
// through a valid/ready handshake until the consumer takes it.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic                clk,
    input  logic                rst,
    inv_sub_bytes_seq_if.slave  bus
);

    localparam int          GROUPS     = AES_BYTES / BYTES_PER_CYCLE;
    localparam int          COUNT_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned BPC_U      = BYTES_PER_CYCLE;
    localparam logic [COUNT_W-1:0] LAST_GROUP = COUNT_W'(GROUPS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    isb_state_e         state;
    logic [COUNT_W-1:0] count;
    aes_state_t         st_reg;
    aes_state_t         st_next;
    logic               ready_q;
    logic               valid_q;

    // First byte index of the group being substituted this cycle.
    int unsigned        grp_base;
    logic               lut_en;
    aes_byte_t          lut_addr [BYTES_PER_CYCLE];
    aes_byte_t          lut_data [BYTES_PER_CYCLE];

    assign grp_base = 32'(count) * BPC_U;
    assign lut_en   = (state == ST_BUSY);

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lut
        assign lut_addr[j] = get_byte(st_reg, grp_base + j);

        inv_sbox u_inv_sbox (
            .valid_in (lut_en),
            .addr     (lut_addr[j]),
            .dout     (lut_data[j])
        );
    end

    // Merge the freshly substituted group back into the working state.
    always_comb begin
        st_next = st_reg;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            st_next = set_byte(st_next, grp_base + j, lut_data[j]);
        end
    end

    // Control FSM, group counter and state register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            st_reg  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    // ready_q gates the accept so no state is taken in the
                    // cycle right after reset, before ready_out is visible.
                    if (bus.valid_in && ready_q) begin
                        st_reg  <= bus.data_in;
                        count   <= '0;
                        ready_q <= 1'b0;
                        state   <= ST_BUSY;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    st_reg <= st_next;
                    if (count == LAST_GROUP) begin
                        count   <= '0;
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.ready_in) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // The state register is frozen in DONE, so it doubles as the result.
    assign bus.ready_out = ready_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = st_reg;

endmodule
